// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory read handshake between the fetch unit and the memory
interface instr_fetch_unit_if #(parameter int XLEN = 32);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I multi-cycle fetch stage (PC, IR, decode fields); immediate generator enabled by IMM_GEN_EN
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                IR_Write,
    input  logic                PC_Write,
    input  logic                pc_load,
    input  logic [XLEN-1:0]     pc_target,
    instr_fetch_unit_if.master  imem,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc_ir,
    output logic [31:0]         ir,
    output logic [6:0]          opcode,
    output logic [4:0]          rd,
    output logic [2:0]          funct3,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [6:0]          funct7,
    output logic [31:0]         imm,
    output logic                fetch_busy,
    output logic                fetch_done
);
    typedef enum logic {IDLE, REQ} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, pc_ir_q, pc_ir_d, addr_q, addr_d, pend_tgt_q, pend_tgt_d;
    logic [31:0]     ir_q, ir_d;
    logic            done_q, done_d, adv_q, adv_d, pend_q, pend_d;
    logic [XLEN-1:0] tgt, fetch_addr;

    assign tgt        = pc_target & ~XLEN'(3);
    assign fetch_addr = pc_load ? tgt : pc_q;

    // state and datapath registers; reset abandons any fetch in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= PC_RESET;
            pc_ir_q    <= PC_RESET;
            addr_q     <= PC_RESET;
            ir_q       <= 32'h0000_0013;
            done_q     <= 1'b0;
            adv_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_ir_q    <= pc_ir_d;
            addr_q     <= addr_d;
            ir_q       <= ir_d;
            done_q     <= done_d;
            adv_q      <= adv_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    // next state: IDLE launches on IR_Write, REQ retires on imem_ready
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && IR_Write)
            state_d = REQ;
        else if (state_q == REQ && imem.imem_ready)
            state_d = IDLE;
    end

    // datapath updates; a redirect seen during REQ is parked until the fetch retires
    always_comb begin
        pc_d       = pc_q;
        pc_ir_d    = pc_ir_q;
        addr_d     = addr_q;
        ir_d       = ir_q;
        done_d     = 1'b0;
        adv_d      = adv_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        if (state_q == IDLE) begin
            if (IR_Write) begin
                addr_d = fetch_addr;
                pc_d   = fetch_addr;
                adv_d  = PC_Write;
            end else if (pc_load) begin
                pc_d = tgt;
            end
        end else if (imem.imem_ready) begin
            ir_d    = imem.imem_rdata;
            pc_ir_d = addr_q;
            pc_d    = pc_load ? tgt : pend_q ? pend_tgt_q : adv_q ? addr_q + XLEN'(4) : addr_q;
            pend_d  = 1'b0;
            done_d  = 1'b1;
        end else if (pc_load) begin
            pend_d     = 1'b1;
            pend_tgt_d = tgt;
        end
    end

    // outputs derived from state; imem_req follows state so reset drops it at once
    always_comb begin
        imem.imem_req  = (state_q == REQ);
        imem.imem_addr = addr_q;
        fetch_busy     = (state_q == REQ);
        fetch_done     = done_q;
    end

    assign pc     = pc_q;
    assign pc_ir  = pc_ir_q;
    assign ir     = ir_q;
    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

`ifdef IMM_GEN_EN
    // immediate selected by instruction format
    always_comb begin
        imm = 32'h0;
        case (ir_q[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: imm = {{20{ir_q[31]}}, ir_q[31:20]};
            7'b0100011: imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            7'b1100011: imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            7'b0110111, 7'b0010111: imm = {ir_q[31:12], 12'b0};
            7'b1101111: imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
    end
`else
    assign imm = 32'h0;
`endif
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the multi-cycle RV32I core. It holds the PC and the instruction register (IR).
- On an IR_Write request from the control unit, it reads one word from instruction memory over a req/ready handshake, latches it into the IR and optionally advances the PC.
- It presents the decoded fields (opcode, funct3, funct7, register indices, immediate) to the control unit and the datapath.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- PC_RESET, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- IR_Write  in  1  fetch request from the control unit; sampled only in IDLE
- PC_Write  in  1  advance PC by 4 when the fetch completes; sampled together with IR_Write
- pc_load  in  1  redirect PC (branch/jump); accepted in any state
- pc_target  in  XLEN  redirect address; bits [1:0] are ignored and forced to 0
- imem_req  out  1  instruction memory read request
- imem_addr  out  XLEN  word-aligned fetch address; stable while imem_req=1
- imem_ready  in  1  memory accepts the request; imem_rdata is valid in the same cycle
- imem_rdata  in  32  instruction word
- pc  out  XLEN  current PC
- pc_ir  out  XLEN  address of the instruction held in ir
- ir  out  32  instruction register
- opcode  out  7  ir[6:0]
- rd  out  5  ir[11:7]
- funct3  out  3  ir[14:12]
- rs1  out  5  ir[19:15]
- rs2  out  5  ir[24:20]
- funct7  out  7  ir[31:25]
- imm  out  32  sign-extended immediate (see Optional Feature)
- fetch_busy  out  1  high while in REQ
- fetch_done  out  1  one-cycle pulse after ir is updated

Behaviour:
- Reset values (asynchronous, with rst_n=0):
  - state=IDLE, pc=PC_RESET, pc_ir=PC_RESET, ir=32'h0000_0013 (NOP)
  - imem_req=0, imem_addr=PC_RESET, fetch_busy=0, fetch_done=0
  - internal adv_flag=0, pend_load=0
- Reset asserted during REQ abandons the fetch. imem_req drops immediately and the memory must tolerate this.
- FSM has two states, IDLE and REQ.
- IDLE with IR_Write=1 at a clock edge:
  - fetch address = pc_load ? {pc_target[31:2],2'b00} : pc
  - imem_addr <= fetch address, pc <= fetch address
  - adv_flag <= PC_Write, imem_req <= 1, state -> REQ
- IDLE with IR_Write=0 and pc_load=1: pc <= {pc_target[31:2],2'b00}; no fetch is issued.
- REQ, general rules:
  - imem_req=1 and imem_addr is held until an edge sees imem_ready=1.
  - IR_Write and PC_Write are ignored in REQ.
- REQ with pc_load=1 and imem_ready=0: pend_load <= 1 and pend_target <= target. The latest redirect wins.
- REQ at the edge with imem_ready=1:
  - ir <= imem_rdata, pc_ir <= imem_addr
  - pc <= pc_load ? target : pend_load ? pend_target : adv_flag ? imem_addr+4 : imem_addr
  - pend_load <= 0, imem_req <= 0, fetch_done <= 1 for exactly one cycle, state -> IDLE
- Latency: with a zero-wait memory, IR_Write sampled at edge T0 gives imem_req high in cycle T0..T1, ir updated at T1, and fetch_done high in cycle T1..T2. Each memory wait cycle adds one cycle.
- Back-to-back fetches: IR_Write held high in the cycle fetch_done is high starts the next fetch at that edge. There is no dead cycle beyond IDLE.
- PC arithmetic is modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0.
- Decoded fields are combinational from ir. They change only when ir changes, so they are stable between fetches.

Optional Feature:
- Macro IMM_GEN_EN.
- Defined: imm is generated combinationally from ir according to opcode:
  - I-type (0010011, 0000011, 1100111): sext(ir[31:20])
  - S-type (0100011): sext({ir[31:25],ir[11:7]})
  - B-type (1100011): sext({ir[31],ir[7],ir[30:25],ir[11:8],1'b0})
  - U-type (0110111, 0010111): {ir[31:12],12'b0}
  - J-type (1101111): sext({ir[31],ir[19:12],ir[20],ir[30:21],1'b0})
  - any other opcode: 0
- Undefined: imm is tied to 32'h0 and the generator logic is absent; the datapath supplies its own immediate unit.

Test Plan:
- Reset, then IR_Write=1 and PC_Write=1 for one cycle, zero-wait memory returning 32'h00500093 -> imem_addr=0; ir=32'h00500093, pc_ir=0, pc=4; fetch_done one cycle; opcode=0010011, rd=1; imm=5 with IMM_GEN_EN.
- Memory holds imem_ready=0 for 3 cycles -> imem_req and imem_addr stable for 4 cycles; fetch_busy=1 throughout; a single fetch_done pulse.
- pc_load=1 with pc_target=32'h0000_0103 during REQ, then ready -> imem_addr unchanged during REQ; pc=32'h0000_0100 after completion (alignment forced, redirect overrides +4).
- IR_Write and pc_load in the same IDLE cycle with target 32'h40 and PC_Write=0 -> imem_addr=32'h40; pc=32'h40 after completion.
- pc=32'hFFFF_FFFC, fetch with PC_Write=1 -> pc=0.
- Assert rst_n=0 mid-REQ -> imem_req falls without waiting for a clock edge; pc=PC_RESET, ir=32'h13; no fetch_done pulse.
